// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: opcodes, funct3 codes and the ALU operation set.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // alt selects SUB/SRA; callers mask it for OP_IMM where only shifts use it.
  function automatic alu_op_e alu_decode(logic [2:0] f3, logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// x1..x31 register file: two operand read ports, one debug read port, one write port.
module rv32i_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic [4:0]  ra3_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  output logic [31:0] rd3_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] regs_q [1:31];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && wa_i != 5'd0) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];
  assign rd3_o = (ra3_i == 5'd0) ? '0 : regs_q[ra3_i];

endmodule

// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core: external instruction fetch, internal little-endian data memory.
module rv32i_single_cycle_core
  import rv32i_pkg::*;
#(
  parameter int          DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_out,
  output logic [31:0] imem_addr,
  input  logic [4:0]  ra3,
  output logic [31:0] rd3
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_v, rs2_v, alu_a, alu_b, alu_y, rf_wd, jalr_tgt;
  logic        rf_we, br_taken, ld_ok;
  alu_op_e     alu_op;

  assign imem_addr = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign opcode = imem_out[6:0];
  assign rd     = imem_out[11:7];
  assign f3     = imem_out[14:12];
  assign rs1    = imem_out[19:15];
  assign rs2    = imem_out[24:20];
  assign f7     = imem_out[31:25];

  assign imm_i = {{20{imem_out[31]}}, imem_out[31:20]};
  assign imm_s = {{20{imem_out[31]}}, imem_out[31:25], imem_out[11:7]};
  assign imm_b = {{19{imem_out[31]}}, imem_out[31], imem_out[7], imem_out[30:25], imem_out[11:8], 1'b0};
  assign imm_u = {imem_out[31:12], 12'h000};
  assign imm_j = {{11{imem_out[31]}}, imem_out[31], imem_out[19:12], imem_out[20], imem_out[30:21], 1'b0};
  assign jalr_tgt = (rs1_v + imm_i) & ~32'd1;

  rv32i_regfile u_rf (
    .clk_i (clk),    .rst_i (rst),
    .ra1_i (rs1),    .ra2_i (rs2),   .ra3_i (ra3),
    .rd1_o (rs1_v),  .rd2_o (rs2_v), .rd3_o (rd3),
    .we_i  (rf_we),  .wa_i  (rd),    .wd_i  (rf_wd)
  );

  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD:  alu_y = alu_a + alu_b;
      ALU_SUB:  alu_y = alu_a - alu_b;
      ALU_SLL:  alu_y = alu_a << alu_b[4:0];
      ALU_SLT:  alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_y = {31'b0, alu_a < alu_b};
      ALU_XOR:  alu_y = alu_a ^ alu_b;
      ALU_SRL:  alu_y = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_y = $signed(alu_a) >>> alu_b[4:0];
      ALU_OR:   alu_y = alu_a | alu_b;
      ALU_AND:  alu_y = alu_a & alu_b;
      default:  alu_y = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (f3)
      F3_BEQ:  br_taken = rs1_v == rs2_v;
      F3_BNE:  br_taken = rs1_v != rs2_v;
      F3_BLT:  br_taken = $signed(rs1_v) <  $signed(rs2_v);
      F3_BGE:  br_taken = $signed(rs1_v) >= $signed(rs2_v);
      F3_BLTU: br_taken = rs1_v <  rs2_v;
      F3_BGEU: br_taken = rs1_v >= rs2_v;
      default: br_taken = 1'b0;
    endcase
  end

  // Data memory: upper address bits above the array size wrap.
  logic [31:0]   dmem_q [DMEM_WORDS] = '{default: '0};
  logic [31:0]   dm_addr, ld_word, ld_data, st_data;
  logic [AW-1:0] widx;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [3:0]    st_be;

  assign dm_addr = rs1_v + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign widx    = dm_addr[AW+1:2];
  assign ld_word = dmem_q[widx];
  assign ld_byte = ld_word[8*dm_addr[1:0] +: 8];
  assign ld_half = dm_addr[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    ld_data = ld_word;
    ld_ok   = 1'b1;
    st_data = rs2_v;
    st_be   = 4'b0000;
    case (f3)
      F3_B: begin
        ld_data = {{24{ld_byte[7]}}, ld_byte};
        st_data = {4{rs2_v[7:0]}};
        st_be   = 4'b0001 << dm_addr[1:0];
      end
      F3_H: begin
        ld_data = {{16{ld_half[15]}}, ld_half};
        st_data = {2{rs2_v[15:0]}};
        st_be   = dm_addr[1] ? 4'b1100 : 4'b0011;
      end
      F3_W:    st_be = 4'b1111;
      F3_BU:   ld_data = {24'b0, ld_byte};
      F3_HU:   ld_data = {16'b0, ld_half};
      default: ld_ok = 1'b0;
    endcase
    if (opcode != OPC_STORE) st_be = 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < 4; b++)
        if (st_be[b]) dmem_q[widx][8*b +: 8] <= st_data[8*b +: 8];
    end
  end

  always_comb begin
    alu_a  = rs1_v;
    alu_b  = rs2_v;
    alu_op = alu_decode(f3, f7[5]);
    rf_we  = 1'b0;
    rf_wd  = alu_y;
    pc_d   = pc_plus4;
    case (opcode)
      OPC_OP:     rf_we = 1'b1;
      OPC_OP_IMM: begin
        alu_b  = imm_i;
        alu_op = alu_decode(f3, (f3 == F3_SR) && f7[5]);
        rf_we  = 1'b1;
      end
      OPC_LUI:    begin rf_we = 1'b1; rf_wd = imm_u;         end
      OPC_AUIPC:  begin rf_we = 1'b1; rf_wd = pc_q + imm_u;  end
      OPC_JAL:    begin rf_we = 1'b1; rf_wd = pc_plus4; pc_d = pc_q + imm_j; end
      OPC_JALR:   begin rf_we = 1'b1; rf_wd = pc_plus4; pc_d = jalr_tgt;     end
      OPC_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
      OPC_LOAD:   begin rf_we = ld_ok; rf_wd = ld_data; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Lockstep bench: directed programs plus random instruction streams against an ISA-level model.
module tb_rv32i_single_cycle_core;

  localparam int DW = 256;
  localparam int MB = DW * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_out, imem_addr, rd3;
  logic [4:0]  ra3 = 5'd0;

  logic [31:0] imem [1024];
  logic [31:0] mx   [32];
  logic [7:0]  mm   [MB];
  logic [31:0] mpc;
  logic [4:0]  last_rd;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  assign imem_out = imem[imem_addr[11:2]];

  rv32i_single_cycle_core #(.DMEM_WORDS(DW), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_out(imem_out), .imem_addr(imem_addr),
    .ra3(ra3), .rd3(rd3)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  // ---- encoders ----
  function automatic logic [31:0] ei(logic [31:0] imm, logic [31:0] rs1, logic [31:0] f3,
                                     logic [31:0] rd, logic [31:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] er(logic [31:0] f7, logic [31:0] rs2, logic [31:0] rs1,
                                     logic [31:0] f3, logic [31:0] rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] es(logic [31:0] imm, logic [31:0] rs2, logic [31:0] rs1,
                                     logic [31:0] f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] eb(logic [31:0] imm, logic [31:0] rs1, logic [31:0] rs2,
                                     logic [31:0] f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] eu(logic [31:0] imm, logic [31:0] rd, logic [31:0] op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] ej(logic [31:0] imm, logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction

  // ---- ISA reference model ----
  function automatic logic [31:0] mread(logic [31:0] ea, int n);
    logic [31:0] base, v;
    base = ea & ~(32'(n) - 32'd1);
    v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(mm[(base + 32'(k)) % MB]) << (8 * k));
    return v;
  endfunction

  task automatic mwrite(logic [31:0] ea, logic [31:0] v, int n);
    logic [31:0] base;
    base = ea & ~(32'(n) - 32'd1);
    for (int k = 0; k < n; k++) mm[(base + 32'(k)) % MB] = 8'(v >> (8 * k));
  endtask

  function automatic logic [31:0] alu_ref(logic [2:0] f3, logic alt, logic [31:0] x, logic [31:0] y);
    case (f3)
      3'd0: return alt ? x - y : x + y;
      3'd1: return x << y[4:0];
      3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: return alt ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  task automatic wr(logic [4:0] rd, logic [31:0] v);
    if (rd != 5'd0) mx[rd] = v;
    last_rd = rd;
  endtask

  task automatic model_step();
    logic [31:0] in, a, b, ii, si, bi, ji, ea, npc, v;
    logic [2:0]  f3;
    logic        tk;
    in  = imem[mpc[11:2]];
    f3  = in[14:12];
    a   = mx[in[19:15]];
    b   = mx[in[24:20]];
    ii  = 32'($signed(in[31:20]));
    si  = 32'($signed({in[31:25], in[11:7]}));
    bi  = 32'($signed({in[31], in[7], in[30:25], in[11:8], 1'b0}));
    ji  = 32'($signed({in[31], in[19:12], in[20], in[30:21], 1'b0}));
    npc = mpc + 32'd4;
    last_rd = 5'd0;
    case (in[6:0])
      7'h37: wr(in[11:7], {in[31:12], 12'h0});
      7'h17: wr(in[11:7], mpc + {in[31:12], 12'h0});
      7'h6F: begin wr(in[11:7], mpc + 32'd4); npc = mpc + ji; end
      7'h67: begin npc = (a + ii) & ~32'd1; wr(in[11:7], mpc + 32'd4); end
      7'h63: begin
        case (f3)
          3'd0: tk = a == b;
          3'd1: tk = a != b;
          3'd4: tk = $signed(a) <  $signed(b);
          3'd5: tk = $signed(a) >= $signed(b);
          3'd6: tk = a <  b;
          3'd7: tk = a >= b;
          default: tk = 1'b0;
        endcase
        if (tk) npc = mpc + bi;
      end
      7'h03: begin
        ea = a + ii;
        case (f3)
          3'd0: begin v = mread(ea, 1); wr(in[11:7], 32'($signed(v[7:0])));  end
          3'd1: begin v = mread(ea, 2); wr(in[11:7], 32'($signed(v[15:0]))); end
          3'd2: wr(in[11:7], mread(ea, 4));
          3'd4: wr(in[11:7], mread(ea, 1));
          3'd5: wr(in[11:7], mread(ea, 2));
          default: ;
        endcase
      end
      7'h23: begin
        ea = a + si;
        case (f3)
          3'd0: mwrite(ea, b, 1);
          3'd1: mwrite(ea, b, 2);
          3'd2: mwrite(ea, b, 4);
          default: ;
        endcase
      end
      7'h13: wr(in[11:7], alu_ref(f3, (f3 == 3'd5) && in[30], a, ii));
      7'h33: wr(in[11:7], alu_ref(f3, in[30], a, b));
      default: ;
    endcase
    mpc = npc;
  endtask

  // ---- drivers ----
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mpc = 32'h0;
    for (int i = 0; i < 32; i++) mx[i] = '0;
    chk("reset_pc", imem_addr, 32'h0);
    ra3 = 5'($urandom); #1;
    chk("reset_reg", rd3, 32'h0);
  endtask

  task automatic step_chk();
    model_step();
    @(posedge clk); #1;
    chk("pc", imem_addr, mpc);
    ra3 = last_rd; #1;
    chk("rd_wb", rd3, mx[last_rd]);
    ra3 = 5'($urandom); #1;
    chk("rand_reg", rd3, mx[ra3]);
  endtask

  task automatic peek(string tag, logic [4:0] r, logic [31:0] exp);
    ra3 = r; #1;
    chk(tag, rd3, exp);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r, f3, imm;
    int sel;
    r   = $urandom;
    sel = $urandom_range(0, 15);
    f3  = 32'($urandom_range(0, 7));
    case (sel)
      0, 1, 2, 3: begin
        imm = {20'b0, r[31:20]};
        if (f3 == 1) imm = {27'b0, r[24:20]};
        if (f3 == 5) imm = {21'b0, r[30], 5'b0, r[24:20]};
        return ei(imm, r[19:15], f3, r[11:7], 32'h13);
      end
      4, 5, 6: return er(((f3 == 0 || f3 == 5) && r[30]) ? 32'h20 : 32'h0,
                         r[24:20], r[19:15], f3, r[11:7]);
      7:  return eu({12'b0, r[31:12]}, r[11:7], r[0] ? 32'h37 : 32'h17);
      8, 9: begin
        case ($urandom_range(0, 4))
          0: f3 = 0; 1: f3 = 1; 2: f3 = 2; 3: f3 = 4; default: f3 = 5;
        endcase
        return ei({20'b0, r[31:20]}, r[19:15], f3, r[11:7], 32'h03);
      end
      10, 11: return es({20'b0, r[31:20]}, r[24:20], r[19:15], 32'($urandom_range(0, 2)));
      12, 13: begin
        case ($urandom_range(0, 5))
          0: f3 = 0; 1: f3 = 1; 2: f3 = 4; 3: f3 = 5; 4: f3 = 6; default: f3 = 7;
        endcase
        return eb(32'($urandom_range(0, 24)) * 4 - 32'd32, r[19:15], r[24:20], f3);
      end
      14: return r[0] ? ej(32'($urandom_range(0, 64)) * 4 - 32'd64, r[11:7])
                      : ei({20'b0, r[31:22], 2'b0}, r[19:15], 0, r[11:7], 32'h67);
      default: begin
        case ($urandom_range(0, 4))
          0: return 32'h0000_000F;
          1: return 32'h0000_0073;
          2: return 32'h0010_0073;
          3: return 32'hFFFF_FFFF;
          default: return 32'h0;
        endcase
      end
    endcase
  endfunction

  initial begin
    int n;
    for (int i = 0; i < MB; i++) mm[i] = 8'h0;
    for (int i = 0; i < 1024; i++) imem[i] = 32'h0;

    // Program 1: negation, SH fill loop, LW readback, byte/half lanes.
    imem[0]  = ei(1, 0, 0, 1, 32'h13);
    imem[1]  = er(32'h20, 1, 0, 0, 1);
    imem[2]  = ei(32'h74, 0, 0, 3, 32'h13);
    imem[3]  = ei(0, 0, 0, 2, 32'h13);
    imem[4]  = es(0, 1, 2, 1);
    imem[5]  = ei(4, 2, 0, 2, 32'h13);
    imem[6]  = eb(8, 2, 3, 0);
    imem[7]  = eb(-12, 0, 0, 0);
    imem[8]  = ei(0, 0, 0, 2, 32'h13);
    for (int k = 3; k < 32; k++) imem[9 + k - 3] = ei(32'(4 * (k - 3)), 2, 2, 32'(k), 32'h03);
    imem[38] = eu(32'h80818, 5, 32'h37);
    imem[39] = ei(32'h283, 5, 0, 5, 32'h13);
    imem[40] = ei(32'h100, 0, 0, 6, 32'h13);
    imem[41] = es(0, 5, 6, 2);
    imem[42] = ei(1, 6, 0, 7, 32'h03);
    imem[43] = ei(3, 6, 4, 8, 32'h03);
    imem[44] = ei(2, 6, 1, 9, 32'h03);
    imem[45] = ei(0, 6, 5, 10, 32'h03);

    do_reset();
    step_chk(); step_chk();
    peek("neg_one", 5'd1, 32'hFFFF_FFFF);
    n = 0;
    while (imem_addr !== 32'h24 && n < 300) begin step_chk(); n++; end
    chk("sh_loop_exit", imem_addr, 32'h24);
    for (int k = 3; k < 32; k++) begin
      step_chk();
      peek("lw_fill", 5'(k), 32'h0000_FFFF);
    end
    repeat (4) step_chk();
    step_chk(); peek("lb_off1",  5'd7,  32'hFFFF_FF82);
    step_chk(); peek("lbu_off3", 5'd8,  32'h0000_0080);
    step_chk(); peek("lh_off2",  5'd9,  32'hFFFF_8081);
    step_chk(); peek("lhu_off0", 5'd10, 32'h0000_8283);

    // Program 2: control flow, x0 and unknown opcode, shifts and compares.
    for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
    imem[0]  = ei(1, 0, 0, 1, 32'h13);
    imem[1]  = ei(-1, 0, 0, 2, 32'h13);
    imem[2]  = eb(12, 1, 1, 1);
    imem[3]  = eb(32'h34, 1, 2, 6);
    imem[16] = ej(16, 3);
    imem[20] = ei(32'h61, 0, 0, 4, 32'h13);
    imem[21] = ei(0, 4, 0, 5, 32'h67);
    imem[24] = ei(5, 0, 0, 0, 32'h13);
    imem[25] = 32'h0;
    imem[26] = eu(32'h80000, 6, 32'h37);
    imem[27] = ei(32'h404, 6, 5, 7, 32'h13);
    imem[28] = ei(4, 6, 5, 8, 32'h13);
    imem[29] = er(0, 1, 2, 2, 9);
    imem[30] = er(0, 1, 2, 3, 10);
    imem[31] = eu(32'h12345, 11, 32'h37);

    do_reset();
    step_chk(); step_chk();
    step_chk(); chk("bne_not_taken", imem_addr, 32'h0C);
    step_chk(); chk("bltu_taken", imem_addr, 32'h40);
    step_chk(); chk("jal_pc", imem_addr, 32'h50); peek("jal_link", 5'd3, 32'h44);
    step_chk();
    step_chk(); chk("jalr_pc", imem_addr, 32'h60); peek("jalr_link", 5'd5, 32'h58);
    step_chk(); peek("x0_write", 5'd0, 32'h0);
    step_chk(); chk("unknown_pc", imem_addr, 32'h68); peek("unknown_x4", 5'd4, 32'h61);
    step_chk();
    step_chk(); peek("srai", 5'd7, 32'hF800_0000);
    step_chk(); peek("srli", 5'd8, 32'h0800_0000);
    step_chk(); peek("slt",  5'd9, 32'h1);
    step_chk(); peek("sltu", 5'd10, 32'h0);
    step_chk(); peek("lui",  5'd11, 32'h1234_5000);

    // Random streams in lockstep with the model.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 1024; i++) imem[i] = rand_inst();
      do_reset();
      repeat (600) step_chk();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
